// File: rtl/aqua_pkg.sv
// -----------------------------------------------------------------------------
// aqua_pkg
// Shared types for the issue path.
//   decode_s    : one decoded instruction as offered by the decode queue
//   sch_state_e : issue_scheduler FSM states
//   ISSUE_W_DEF : default issue-group width (lanes)
//   REG_AW_DEF  : architectural register address width
// -----------------------------------------------------------------------------
package aqua_pkg;

  localparam int ISSUE_W_DEF = 2;
  localparam int REG_AW_DEF  = 5;
  localparam int FUNCT_W     = 10;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd_addr;
    logic                  rd_wren;
    logic [REG_AW_DEF-1:0] rs1_addr;
    logic                  rs1_rden;
    logic [REG_AW_DEF-1:0] rs2_addr;
    logic                  rs2_rden;
    logic                  mem_access;
    logic [FUNCT_W-1:0]    funct;
  } decode_s;

  // IDLE  : nothing held, scheduler may pull a new group
  // SPLIT : remainder of a split group waits in the pending buffer
  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } sch_state_e;

endpackage

// File: rtl/sch_hazard_chk.sv
// -----------------------------------------------------------------------------
// sch_hazard_chk
// Purely combinational. Given a slice of ISSUE_W lanes (lane 0 oldest), returns
// the length of the hazard-free prefix: the position of the first valid lane
// j>0 that reads (rs1/rs2 with rden) or writes an rd written by an earlier
// valid lane, ignoring x0. With no such lane the whole slice is the prefix.
//   i_slice      : lanes to examine
//   o_prefix_len : number of leading lane positions safe to issue together
// Optional feature macro: SCH_MEM_PORT_CHECK_EN -- also ends the prefix at the
// second valid mem_access lane (single memory port).
// -----------------------------------------------------------------------------
module sch_hazard_chk
  import aqua_pkg::*;
#(
  parameter  int ISSUE_W = ISSUE_W_DEF,
  parameter  int REG_AW  = REG_AW_DEF,
  localparam int CNT_W   = $clog2(ISSUE_W + 1)
) (
  input  decode_s          i_slice [ISSUE_W],
  output logic [CNT_W-1:0] o_prefix_len
);

  function automatic logic reg_eq(input logic [REG_AW_DEF-1:0] a,
                                  input logic [REG_AW_DEF-1:0] b);
    return REG_AW'(a) == REG_AW'(b);
  endfunction

  always_comb begin
    logic found;
    logic hit;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned -- that is what keeps latches from appearing.
    o_prefix_len = CNT_W'(ISSUE_W);
    found        = 1'b0;
    hit          = 1'b0;
    for (int j = 1; j < ISSUE_W; j++) begin
      hit = 1'b0;
      for (int i = 0; i < j; i++) begin
        if (i_slice[i].valid && i_slice[i].rd_wren && (i_slice[i].rd_addr != '0)) begin
          if ((i_slice[j].rs1_rden && reg_eq(i_slice[j].rs1_addr, i_slice[i].rd_addr)) ||
              (i_slice[j].rs2_rden && reg_eq(i_slice[j].rs2_addr, i_slice[i].rd_addr)) ||
              (i_slice[j].rd_wren  && reg_eq(i_slice[j].rd_addr,  i_slice[i].rd_addr))) begin
            hit = 1'b1;
          end
        end
`ifdef SCH_MEM_PORT_CHECK_EN
        if (i_slice[i].valid && i_slice[i].mem_access && i_slice[j].mem_access) begin
          hit = 1'b1;
        end
`endif
      end
      // Only the first conflicting valid lane sets the boundary.
      if (i_slice[j].valid && hit && !found) begin
        found        = 1'b1;
        o_prefix_len = CNT_W'(j);
      end
    end
  end

  // Fields this block never looks at, folded so they read as consumed.
  logic unused_bits;
  always_comb begin
    unused_bits = i_slice[0].rs1_rden ^ i_slice[0].rs2_rden ^
                  (^i_slice[0].rs1_addr) ^ (^i_slice[0].rs2_addr);
    for (int i = 0; i < ISSUE_W; i++) begin
      unused_bits = unused_bits ^ (^i_slice[i].funct);
`ifndef SCH_MEM_PORT_CHECK_EN
      unused_bits = unused_bits ^ i_slice[i].mem_access;
`endif
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
// Pulls issue groups from the decode queue and issues the hazard-free prefix of
// each group one cycle after transfer. Any remainder is held compacted in a
// pending buffer and issued on following non-stalled cycles (SPLIT state).
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_dque_sch_decode   : offered group, lane 0 oldest
//   i_dque_sch_ready    : decode queue holds a complete group
//   i_dque_sch_ack      : queue presents the group this cycle
//   i_stall             : backend cannot accept; everything holds
//   o_sch_dque_request  : scheduler pulls a new group (combinational)
//   o_sch_decode        : issued lanes, compacted at lane 0, registered
//   o_sch_issue_cnt     : number of valid issued lanes
// Optional feature macro: SCH_MEM_PORT_CHECK_EN (see sch_hazard_chk).
// -----------------------------------------------------------------------------
module issue_scheduler
  import aqua_pkg::*;
#(
  parameter  int ISSUE_W = ISSUE_W_DEF,
  parameter  int REG_AW  = REG_AW_DEF,
  localparam int CNT_W   = $clog2(ISSUE_W + 1),
  localparam int IDX_W   = $clog2(ISSUE_W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  decode_s          i_dque_sch_decode [ISSUE_W],
  input  logic             i_dque_sch_ready,
  input  logic             i_dque_sch_ack,
  input  logic             i_stall,
  output logic             o_sch_dque_request,
  output decode_s          o_sch_decode [ISSUE_W],
  output logic [CNT_W-1:0] o_sch_issue_cnt
);

  sch_state_e       state_q, state_d;
  decode_s          pend_q [ISSUE_W];
  decode_s          pend_d [ISSUE_W];
  decode_s          out_q  [ISSUE_W];
  decode_s          out_d  [ISSUE_W];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  decode_s          slice  [ISSUE_W];
  logic [CNT_W-1:0] prefix_len;
  logic             xfer;

  assign o_sch_dque_request = i_dque_sch_ready & ~i_stall & (state_q == IDLE) & ~i_rst;
  assign xfer               = o_sch_dque_request & i_dque_sch_ack;

  // Work on the pending remainder in SPLIT, the incoming group on a transfer,
  // otherwise an empty slice so the outputs drain to count 0.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) slice[i] = '0;
    if (state_q == SPLIT) begin
      slice = pend_q;
    end else if (xfer) begin
      slice = i_dque_sch_decode;
    end
  end

  sch_hazard_chk #(
    .ISSUE_W (ISSUE_W),
    .REG_AW  (REG_AW)
  ) u_hazard_chk (
    .i_slice      (slice),
    .o_prefix_len (prefix_len)
  );

  always_comb begin
    logic [CNT_W-1:0] n_issue;
    logic [CNT_W-1:0] n_rem;
    state_d = state_q;
    pend_d  = pend_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    n_issue = '0;
    n_rem   = '0;
    if (!i_stall) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        out_d[i]  = '0;
        pend_d[i] = '0;
      end
      // NOTE: blocking assignments here are deliberate: the running counters
      // must be seen updated by the next loop iteration within the same pass.
      for (int i = 0; i < ISSUE_W; i++) begin
        if (slice[i].valid) begin
          if (CNT_W'(i) < prefix_len) begin
            out_d[n_issue[IDX_W-1:0]] = slice[i];
            n_issue                   = n_issue + 1'b1;
          end else begin
            pend_d[n_rem[IDX_W-1:0]] = slice[i];
            n_rem                    = n_rem + 1'b1;
          end
        end
      end
      cnt_d   = n_issue;
      state_d = (n_rem != '0) ? SPLIT : IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the pending buffer is reset too, not just the state: a stale
      // valid bit left there would resurface as a ghost remainder.
      for (int i = 0; i < ISSUE_W; i++) begin
        pend_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  assign o_sch_decode    = out_q;
  assign o_sch_issue_cnt = cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
// Drives a 2-lane and a 4-lane issue_scheduler with the same stimulus (the
// 2-lane one sees lanes 0..1 of each group). A queue-based reference model
// tracks issue groups and the pending remainder for each width; directed
// sequences pin the model with hand-computed values, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;
  import aqua_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst, ready, ack, stall;
  decode_s grp [4];
  decode_s g2  [2];
  decode_s g4  [4];

  logic       req2, req4;
  decode_s    o2 [2];
  decode_s    o4 [4];
  logic [1:0] cnt2;
  logic [2:0] cnt4;

  assign g2[0] = grp[0];
  assign g2[1] = grp[1];
  assign g4    = grp;

  issue_scheduler #(.ISSUE_W(2), .REG_AW(5)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_dque_sch_decode(g2), .i_dque_sch_ready(ready),
    .i_dque_sch_ack(ack), .i_stall(stall), .o_sch_dque_request(req2),
    .o_sch_decode(o2), .o_sch_issue_cnt(cnt2));

  issue_scheduler #(.ISSUE_W(4), .REG_AW(5)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_dque_sch_decode(g4), .i_dque_sch_ready(ready),
    .i_dque_sch_ack(ack), .i_stall(stall), .o_sch_dque_request(req4),
    .o_sch_decode(o4), .o_sch_issue_cnt(cnt4));

  // Reference model state, index 0 = 2-lane DUT, 1 = 4-lane DUT.
  decode_s m_pend [2][4];
  int      m_pcnt [2];
  decode_s m_out  [2][4];
  int      m_cnt  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic decode_s mk(input int rd, input logic wr, input int rs1, input logic r1,
                                 input int rs2, input logic r2, input logic mem);
    decode_s d;
    d            = '0;
    d.valid      = 1'b1;
    d.rd_addr    = 5'(rd);
    d.rd_wren    = wr;
    d.rs1_addr   = 5'(rs1);
    d.rs1_rden   = r1;
    d.rs2_addr   = 5'(rs2);
    d.rs2_rden   = r2;
    d.mem_access = mem;
    return d;
  endfunction

  function automatic decode_s rand_ins();
    decode_s d;
    d.valid      = ($urandom_range(0, 6) != 0);
    d.rd_addr    = 5'($urandom_range(0, 3));
    d.rd_wren    = ($urandom_range(0, 3) != 0);
    d.rs1_addr   = 5'($urandom_range(0, 3));
    d.rs1_rden   = 1'($urandom_range(0, 1));
    d.rs2_addr   = 5'($urandom_range(0, 3));
    d.rs2_rden   = 1'($urandom_range(0, 1));
    d.mem_access = ($urandom_range(0, 2) == 0);
    d.funct      = 10'($urandom);
    return d;
  endfunction

  // Would issuing ins alongside the already-issued lanes break a rule?
  function automatic logic conflict(input decode_s ins, input logic [31:0] written, input int mem_seen);
    logic c;
    c = (ins.rs1_rden && written[ins.rs1_addr]) ||
        (ins.rs2_rden && written[ins.rs2_addr]) ||
        (ins.rd_wren  && written[ins.rd_addr]);
`ifdef SCH_MEM_PORT_CHECK_EN
    if (ins.mem_access && mem_seen > 0) c = 1'b1;
`endif
    return c;
  endfunction

  function automatic logic exp_req(input int k);
    return ready & ~stall & ~rst & (m_pcnt[k] == 0);
  endfunction

  task automatic model_step(input int k, input int w, input logic xfer);
    decode_s     sl [$];
    decode_s     rem [$];
    logic [31:0] written;
    int          mem_seen;
    logic        stop;
    int          n;
    if (rst) begin
      m_pcnt[k] = 0;
      m_cnt[k]  = 0;
      for (int l = 0; l < 4; l++) m_out[k][l] = '0;
      return;
    end
    if (stall) return;
    if (m_pcnt[k] > 0) begin
      for (int l = 0; l < m_pcnt[k]; l++) sl.push_back(m_pend[k][l]);
    end else if (xfer) begin
      for (int l = 0; l < w; l++) sl.push_back(grp[l]);
    end
    written  = '0;
    mem_seen = 0;
    stop     = 1'b0;
    n        = 0;
    for (int l = 0; l < 4; l++) m_out[k][l] = '0;
    for (int j = 0; j < sl.size(); j++) begin
      if (sl[j].valid) begin
        if (j > 0 && conflict(sl[j], written, mem_seen)) stop = 1'b1;
        if (stop) begin
          rem.push_back(sl[j]);
        end else begin
          m_out[k][n] = sl[j];
          n++;
          if (sl[j].rd_wren && sl[j].rd_addr != 0) written[sl[j].rd_addr] = 1'b1;
          if (sl[j].mem_access) mem_seen++;
        end
      end
    end
    m_cnt[k]  = n;
    m_pcnt[k] = rem.size();
    for (int l = 0; l < rem.size(); l++) m_pend[k][l] = rem[l];
  endtask

  task automatic compare_outputs();
    check("cnt_w2", 32'(cnt2), 32'(m_cnt[0]));
    for (int l = 0; l < 2; l++) begin
      check($sformatf("valid_w2_l%0d", l), 32'(o2[l].valid), 32'(l < m_cnt[0]));
      if (l < m_cnt[0]) check($sformatf("lane_w2_l%0d", l), 32'(o2[l]), 32'(m_out[0][l]));
    end
    check("cnt_w4", 32'(cnt4), 32'(m_cnt[1]));
    for (int l = 0; l < 4; l++) begin
      check($sformatf("valid_w4_l%0d", l), 32'(o4[l].valid), 32'(l < m_cnt[1]));
      if (l < m_cnt[1]) check($sformatf("lane_w4_l%0d", l), 32'(o4[l]), 32'(m_out[1][l]));
    end
  endtask

  // One clock cycle: apply inputs, check the combinational request, advance
  // the model, then check registered outputs just after the edge.
  task automatic cyc(input logic r, input logic rd, input logic ak, input logic st);
    logic x2, x4;
    rst   = r;
    ready = rd;
    ack   = ak;
    stall = st;
    #1;
    check("req_w2", 32'(req2), 32'(exp_req(0)));
    check("req_w4", 32'(req4), 32'(exp_req(1)));
    x2 = exp_req(0) & ak;
    x4 = exp_req(1) & ak;
    model_step(0, 2, x2);
    model_step(1, 4, x4);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic clear_grp();
    for (int l = 0; l < 4; l++) grp[l] = '0;
  endtask

  task automatic load_raw_pair();
    clear_grp();
    grp[0] = mk(1, 1, 2, 1, 3, 1, 0);   // add x1,x2,x3
    grp[1] = mk(7, 1, 1, 1, 2, 1, 0);   // add x7,x1,x2
  endtask

  initial begin
    m_pcnt = '{0, 0};
    m_cnt  = '{0, 0};
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < 4; l++) begin
        m_pend[k][l] = '0;
        m_out[k][l]  = '0;
      end
    clear_grp();
    rst = 1'b1; ready = 1'b0; ack = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;

    // Reset with ready high: request must stay low, outputs empty.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("rst_req_low", 32'(req2), 32'd0);
    check("rst_cnt", 32'(cnt2), 32'd0);

    // Independent pair issues together; request stays high afterwards.
    clear_grp();
    grp[0] = mk(1, 1, 2, 1, 3, 1, 0);
    grp[1] = mk(4, 1, 5, 1, 6, 1, 0);
    cyc(0, 1, 1, 0);
    check("pair_cnt", 32'(cnt2), 32'd2);
    check("pair_l0_rd", 32'(o2[0].rd_addr), 32'd1);
    check("pair_l1_rd", 32'(o2[1].rd_addr), 32'd4);
    check("pair_req_high", 32'(req2), 32'd1);
    clear_grp();
    cyc(0, 0, 0, 0);
    check("idle_cnt0", 32'(cnt2), 32'd0);

    // RAW hazard splits the pair across two cycles.
    load_raw_pair();
    cyc(0, 1, 1, 0);
    check("raw_c1_cnt", 32'(cnt2), 32'd1);
    check("raw_c1_rd", 32'(o2[0].rd_addr), 32'd1);
    check("raw_c1_req", 32'(req2), 32'd0);
    cyc(0, 1, 0, 0);
    check("raw_c2_cnt", 32'(cnt2), 32'd1);
    check("raw_c2_rd", 32'(o2[0].rd_addr), 32'd7);
    check("raw_c2_req", 32'(req2), 32'd1);

    // Four-lane chain splits into {x1}, {x2,x3}, {x4}.
    clear_grp();
    grp[0] = mk(1, 1, 0, 0, 0, 0, 0);
    grp[1] = mk(2, 1, 1, 1, 0, 0, 0);
    grp[2] = mk(3, 1, 0, 0, 0, 0, 0);
    grp[3] = mk(4, 1, 3, 1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    check("w4_c1_cnt", 32'(cnt4), 32'd1);
    check("w4_c1_rd", 32'(o4[0].rd_addr), 32'd1);
    check("w4_c1_req", 32'(req4), 32'd0);
    cyc(0, 1, 0, 0);
    check("w4_c2_cnt", 32'(cnt4), 32'd2);
    check("w4_c2_rd0", 32'(o4[0].rd_addr), 32'd2);
    check("w4_c2_rd1", 32'(o4[1].rd_addr), 32'd3);
    check("w4_c2_req", 32'(req4), 32'd0);
    cyc(0, 1, 0, 0);
    check("w4_c3_cnt", 32'(cnt4), 32'd1);
    check("w4_c3_rd", 32'(o4[0].rd_addr), 32'd4);
    check("w4_c3_req", 32'(req4), 32'd1);
    clear_grp();
    cyc(0, 0, 0, 0);

    // Split, then stall three cycles: outputs frozen, remainder after release.
    load_raw_pair();
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1);
    check("stall_cnt", 32'(cnt2), 32'd1);
    check("stall_rd", 32'(o2[0].rd_addr), 32'd1);
    cyc(0, 0, 0, 0);
    check("unstall_cnt", 32'(cnt2), 32'd1);
    check("unstall_rd", 32'(o2[0].rd_addr), 32'd7);
    cyc(0, 0, 0, 0);

    // Reset mid-SPLIT (with stall and ack high) discards the remainder.
    load_raw_pair();
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 1);
    check("rst_split_cnt", 32'(cnt2), 32'd0);
    check("rst_split_v0", 32'(o2[0].valid), 32'd0);
    clear_grp();
    cyc(0, 1, 0, 0);
    check("rst_split_after_cnt", 32'(cnt2), 32'd0);
    check("rst_split_req", 32'(req2), 32'd1);

    // All-invalid group is accepted with count 0.
    clear_grp();
    cyc(0, 1, 1, 0);
    check("empty_grp_cnt", 32'(cnt2), 32'd0);
    check("empty_grp_req", 32'(req2), 32'd1);

    // lw x1 ; sw x2 -- split only with the memory-port limit enabled.
    clear_grp();
    grp[0] = mk(1, 1, 10, 1, 0, 0, 1);
    grp[1] = mk(0, 0, 11, 1, 2, 1, 1);
    cyc(0, 1, 1, 0);
`ifdef SCH_MEM_PORT_CHECK_EN
    check("mem_c1_cnt", 32'(cnt2), 32'd1);
    clear_grp();
    cyc(0, 0, 0, 0);
    check("mem_c2_cnt", 32'(cnt2), 32'd1);
`else
    check("mem_c1_cnt", 32'(cnt2), 32'd2);
    clear_grp();
    cyc(0, 0, 0, 0);
    check("mem_c2_cnt", 32'(cnt2), 32'd0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 4; l++) grp[l] = rand_ins();
      cyc(($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 4) < 3),
          ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
